pwm_adc_avg: RTL and testbench

//  Downstream consumer of the PWM-ramp ADC sample stream (value + 1-cycle valid pulse).

---
 rtl/pwm_adc_avg_pkg.sv | 24 ++
 rtl/pwm_adc_avg_minmax.sv | 61 ++++++
 rtl/pwm_adc_avg.sv | 177 +++++++++++++++++
 tb/tb_pwm_adc_avg.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_adc_avg_pkg.sv
// Shared types and helpers for the pwm_adc_avg sample averager.
//  - state_t      : averaging FSM states
//  - acc_width()  : accumulator width for a given sample width / max window exponent
//  - clamp_log2() : saturate a requested window exponent to the supported maximum
package pwm_adc_avg_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    localparam int unsigned NBITS_DEF    = 8;
    localparam int unsigned MAX_LOG2_DEF = 4;

    // Sum of 2^max_log2 samples of nbits each fits exactly in nbits+max_log2 bits.
    function automatic int unsigned acc_width(int unsigned nbits, int unsigned max_log2);
        return nbits + max_log2;
    endfunction

    function automatic int unsigned clamp_log2(int unsigned req, int unsigned max_log2);
        return (req > max_log2) ? max_log2 : req;
    endfunction

endpackage

// File: rtl/pwm_adc_avg_minmax.sv
// Running per-window min/max tracker for pwm_adc_avg.
// Build option: only instantiated when PWM_ADC_AVG_MINMAX_EN is defined.
// Ports:
//  clk_i, rst_i  clock / synchronous active-high reset
//  clear_i       synchronous flush of running and published values
//  sample_i      ADC code
//  accept_i      sample_i is part of the current window
//  first_i       accepted sample opens a new window
//  load_i        window result is being published (same cycle as the final sample)
//  min_o, max_o  published min/max of the last loaded window
module pwm_adc_avg_minmax #(
    parameter int unsigned NBITS = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic [NBITS-1:0] sample_i,
    input  logic             accept_i,
    input  logic             first_i,
    input  logic             load_i,
    output logic [NBITS-1:0] min_o,
    output logic [NBITS-1:0] max_o
);

    logic [NBITS-1:0] run_min;
    logic [NBITS-1:0] run_max;
    logic [NBITS-1:0] win_min;
    logic [NBITS-1:0] win_max;

    // Min/max including the current sample; a new window ignores stale running values.
    always_comb begin
        win_min = run_min;
        win_max = run_max;
        if (first_i) begin
            win_min = sample_i;
            win_max = sample_i;
        end else begin
            if (sample_i < run_min) win_min = sample_i;
            if (sample_i > run_max) win_max = sample_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            run_min <= '0;
            run_max <= '0;
            min_o   <= '0;
            max_o   <= '0;
        end else begin
            if (accept_i) begin
                run_min <= win_min;
                run_max <= win_max;
            end
            if (load_i) begin
                min_o <= win_min;
                max_o <= win_max;
            end
        end
    end

endmodule

// File: rtl/pwm_adc_avg.sv
// Averages 2^win_log2 consecutive ADC samples and presents the result on a
// valid/ready output; sticky overrun when a result is dropped while one is pending.
// Build option: PWM_ADC_AVG_MINMAX_EN adds per-window min_o/max_o outputs.
// Ports:
//  clk_i, rst_i               clock / synchronous active-high reset
//  enable_i                   accept samples when high; falling mid-window discards it
//  clear_i                    synchronous flush of window, result and flags
//  win_log2_i                 window exponent, latched at window start, clamped to MAX_LOG2
//  sample_i, sample_valid_i   input sample stream
//  avg_o, avg_valid_o         averaged result, held until avg_ready_i
//  avg_ready_i                consumer accept
//  overrun_o                  sticky dropped-result flag
//  busy_o                     window partially filled
//  min_o, max_o               (option) per-window min/max
module pwm_adc_avg
    import pwm_adc_avg_pkg::*;
#(
    parameter int unsigned NBITS    = NBITS_DEF,
    parameter int unsigned MAX_LOG2 = MAX_LOG2_DEF
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             enable_i,
    input  logic                             clear_i,
    input  logic [$clog2(MAX_LOG2+1)-1:0]    win_log2_i,
    input  logic [NBITS-1:0]                 sample_i,
    input  logic                             sample_valid_i,
    output logic [NBITS-1:0]                 avg_o,
    output logic                             avg_valid_o,
    input  logic                             avg_ready_i,
    output logic                             overrun_o,
`ifdef PWM_ADC_AVG_MINMAX_EN
    output logic [NBITS-1:0]                 min_o,
    output logic [NBITS-1:0]                 max_o,
`endif
    output logic                             busy_o
);

    localparam int unsigned ACC_W = acc_width(NBITS, MAX_LOG2);
    localparam int unsigned CNT_W = MAX_LOG2 + 1;
    localparam int unsigned WL_W  = $clog2(MAX_LOG2 + 1);

    state_t            state;
    state_t            state_n;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [WL_W-1:0]   win;
    logic [WL_W-1:0]   win_n;
    logic [NBITS-1:0]  avg_n;
    logic              valid_n;
    logic              ovr_n;

    logic [WL_W-1:0]   win_eff;
    logic [WL_W-1:0]   shamt;
    logic [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt_inc;
    logic [NBITS-1:0]  result;
    logic              sample_acc;
    logic              done;
    logic              take;
    logic              drop;
    logic              load;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) state <= S_IDLE;
        else                  state <= state_n;
    end

    // Next-state, window datapath and output handshake.
    always_comb begin
        state_n    = state;
        acc_n      = acc;
        cnt_n      = cnt;
        win_n      = win;
        avg_n      = avg_o;
        valid_n    = avg_valid_o;
        ovr_n      = overrun_o;
        done       = 1'b0;

        sample_acc = enable_i & sample_valid_i;
        win_eff    = WL_W'(clamp_log2(32'(win_log2_i), MAX_LOG2));
        // acc is zero in S_IDLE, so sum is just the sample when a window opens.
        shamt      = (state == S_IDLE) ? win_eff : win;
        sum        = acc + ACC_W'(sample_i);
        cnt_inc    = cnt + CNT_W'(1);
        result     = NBITS'(sum >> shamt);

        case (state)
            S_IDLE: begin
                if (sample_acc) begin
                    win_n = win_eff;
                    if (win_eff == '0) begin
                        done = 1'b1;
                    end else begin
                        state_n = S_ACCUM;
                        acc_n   = sum;
                        cnt_n   = cnt_inc;
                    end
                end
            end
            S_ACCUM: begin
                if (!enable_i) begin
                    state_n = S_IDLE;
                    acc_n   = '0;
                    cnt_n   = '0;
                end else if (sample_valid_i) begin
                    if (cnt_inc == (CNT_W'(1) << win)) begin
                        done    = 1'b1;
                        state_n = S_IDLE;
                        acc_n   = '0;
                        cnt_n   = '0;
                    end else begin
                        acc_n = sum;
                        cnt_n = cnt_inc;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                acc_n   = '0;
                cnt_n   = '0;
            end
        endcase

        // A completion only loses its result if the pending one is not taken this cycle.
        take = avg_valid_o & avg_ready_i;
        drop = done & avg_valid_o & ~avg_ready_i;
        load = done & ~drop;

        if (take) valid_n = 1'b0;
        if (drop) ovr_n   = 1'b1;
        if (load) begin
            avg_n   = result;
            valid_n = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            acc         <= '0;
            cnt         <= '0;
            win         <= '0;
            avg_o       <= '0;
            avg_valid_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            acc         <= acc_n;
            cnt         <= cnt_n;
            win         <= win_n;
            avg_o       <= avg_n;
            avg_valid_o <= valid_n;
            overrun_o   <= ovr_n;
            busy_o      <= (state_n == S_ACCUM);
        end
    end

`ifdef PWM_ADC_AVG_MINMAX_EN
    pwm_adc_avg_minmax #(
        .NBITS (NBITS)
    ) u_minmax (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (clear_i),
        .sample_i (sample_i),
        .accept_i (sample_acc),
        .first_i  (state == S_IDLE),
        .load_i   (load),
        .min_o    (min_o),
        .max_o    (max_o)
    );
`endif

endmodule

// File: tb/tb_pwm_adc_avg.sv
// Self-checking bench for pwm_adc_avg: directed vector table, hand-written
// multi-cycle sequences, then random stimulus against a window-queue model.
// Build option: PWM_ADC_AVG_MINMAX_EN also checks min_o/max_o.
module tb_pwm_adc_avg;

    localparam int NBITS    = 8;
    localparam int MAX_LOG2 = 4;
    localparam int WL_W     = $clog2(MAX_LOG2 + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             clear;
    logic [WL_W-1:0]  win_log2;
    logic [NBITS-1:0] sample;
    logic             sample_valid;
    logic [NBITS-1:0] avg;
    logic             avg_valid;
    logic             avg_ready;
    logic             overrun;
    logic             busy;
`ifdef PWM_ADC_AVG_MINMAX_EN
    logic [NBITS-1:0] min_v;
    logic [NBITS-1:0] max_v;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pwm_adc_avg #(.NBITS(NBITS), .MAX_LOG2(MAX_LOG2)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .clear_i        (clear),
        .win_log2_i     (win_log2),
        .sample_i       (sample),
        .sample_valid_i (sample_valid),
        .avg_o          (avg),
        .avg_valid_o    (avg_valid),
        .avg_ready_i    (avg_ready),
        .overrun_o      (overrun),
`ifdef PWM_ADC_AVG_MINMAX_EN
        .min_o          (min_v),
        .max_o          (max_v),
`endif
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst; bit en; bit clr; int win; int s; bit sv; bit rdy;
        bit ev;  int ea; bit eo;  bit eb;  bit ca;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit e, bit c, int w, int s, bit sv, bit rd,
                                bit ev, int ea, bit eo, bit eb, bit ca);
        vec_t v;
        v.rst = r; v.en = e; v.clr = c; v.win = w; v.s = s; v.sv = sv; v.rdy = rd;
        v.ev = ev; v.ea = ea; v.eo = eo; v.eb = eb; v.ca = ca;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit c, input int w,
                         input int s, input bit sv, input bit rd);
        rst = r; enable = e; clear = c; win_log2 = WL_W'(w);
        sample = NBITS'(s); sample_valid = sv; avg_ready = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: window contents held in a queue, result by division.
    int m_q[$];
    int m_win;
    int m_avg, m_valid, m_ovr, m_busy, m_min, m_max;

    task automatic model_step();
        bit done;
        int sum, mn, mx, res, pending;
        if (rst || clear) begin
            m_q.delete(); m_win = 0;
            m_avg = 0; m_valid = 0; m_ovr = 0; m_busy = 0; m_min = 0; m_max = 0;
            return;
        end
        done = 0; res = 0; mn = 0; mx = 0;
        pending = m_valid;
        if (!enable) begin
            m_q.delete();
        end else if (sample_valid) begin
            if (m_q.size() == 0) m_win = (int'(win_log2) > MAX_LOG2) ? MAX_LOG2 : int'(win_log2);
            m_q.push_back(int'(sample));
            if (m_q.size() == (1 << m_win)) begin
                sum = 0; mn = 1 << NBITS; mx = -1;
                foreach (m_q[i]) begin
                    sum += m_q[i];
                    if (m_q[i] < mn) mn = m_q[i];
                    if (m_q[i] > mx) mx = m_q[i];
                end
                res = sum / m_q.size();
                m_q.delete();
                done = 1;
            end
        end
        if (done) begin
            if (pending && !avg_ready) m_ovr = 1;
            else begin m_avg = res; m_valid = 1; m_min = mn; m_max = mx; end
        end else if (pending && avg_ready) begin
            m_valid = 0;
        end
        m_busy = (m_q.size() > 0) ? 1 : 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst en clr win s sv rdy | ev ea eo eb ca
        vecs.push_back(mk(1,0,0,0,  0,0,0, 0,  0,0,0,1));
        vecs.push_back(mk(0,1,0,2, 10,1,1, 0,  0,0,1,0));
        vecs.push_back(mk(0,1,0,2, 20,1,1, 0,  0,0,1,0));
        vecs.push_back(mk(0,1,0,2, 30,1,1, 0,  0,0,1,0));
        vecs.push_back(mk(0,1,0,2, 40,1,1, 1, 25,0,0,0));
        vecs.push_back(mk(0,1,0,2,  0,0,1, 0,  0,0,0,0));
        vecs.push_back(mk(0,1,0,0,  7,1,0, 1,  7,0,0,0));
        vecs.push_back(mk(0,1,0,0,200,1,1, 1,200,0,0,0));
        vecs.push_back(mk(0,1,0,0,  0,0,1, 0,  0,0,0,0));
        vecs.push_back(mk(0,1,0,1,  4,1,0, 0,  0,0,1,0));
        vecs.push_back(mk(0,1,0,1,  6,1,0, 1,  5,0,0,0));
        vecs.push_back(mk(0,1,0,1,  8,1,0, 1,  5,0,1,0));
        vecs.push_back(mk(0,1,0,1,  8,1,0, 1,  5,1,0,0));
        vecs.push_back(mk(0,1,0,1,  0,0,0, 1,  5,1,0,0));
        vecs.push_back(mk(0,1,0,1,  0,0,1, 0,  0,1,0,0));
        vecs.push_back(mk(0,1,1,1,  0,0,0, 0,  0,0,0,0));
        vecs.push_back(mk(0,1,0,3,  1,1,0, 0,  0,0,1,0));
        vecs.push_back(mk(0,1,0,3,  2,1,0, 0,  0,0,1,0));
        vecs.push_back(mk(0,1,0,3,  3,1,0, 0,  0,0,1,0));
        vecs.push_back(mk(0,1,1,3,  0,0,0, 0,  0,0,0,0));
        for (int i = 0; i < 7; i++) vecs.push_back(mk(0,1,0,3,255,1,0, 0,0,0,1,0));
        vecs.push_back(mk(0,1,0,3,255,1,0, 1,255,0,0,0));
        vecs.push_back(mk(0,1,0,3,  0,0,1, 0,  0,0,0,0));

        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].win,
                  vecs[i].s, vecs[i].sv, vecs[i].rdy);
            step();
            chk($sformatf("vec%0d_valid", i), int'(avg_valid), int'(vecs[i].ev));
            chk($sformatf("vec%0d_overrun", i), int'(overrun), int'(vecs[i].eo));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].eb));
            if (vecs[i].ev || vecs[i].ca)
                chk($sformatf("vec%0d_avg", i), int'(avg), vecs[i].ea);
        end

        // Clamped window: request 7 -> 16 samples of 3..18, average 168/16 = 10.
        for (int k = 0; k < 16; k++) begin
            drive(0, 1, 0, 7, 3 + k, 1, 0);
            step();
            if (k < 15) begin
                chk($sformatf("clamp_busy%0d", k), int'(busy), 1);
                chk($sformatf("clamp_valid%0d", k), int'(avg_valid), 0);
            end
        end
        chk("clamp_valid", int'(avg_valid), 1);
        chk("clamp_avg", int'(avg), 10);
        chk("clamp_busy_end", int'(busy), 0);
`ifdef PWM_ADC_AVG_MINMAX_EN
        chk("clamp_min", int'(min_v), 3);
        chk("clamp_max", int'(max_v), 18);
`endif
        drive(0, 1, 0, 7, 0, 0, 1);
        step();
        chk("clamp_accept", int'(avg_valid), 0);

        // Enable falling mid-window discards it; mid-window exponent change is ignored.
        drive(0, 1, 0, 2, 50, 1, 0); step();
        drive(0, 1, 0, 2, 60, 1, 0); step();
        chk("abort_busy_before", int'(busy), 1);
        drive(0, 0, 0, 2, 99, 1, 0); step();
        chk("abort_busy_after", int'(busy), 0);
        chk("abort_no_result", int'(avg_valid), 0);
        drive(0, 1, 0, 2, 100, 1, 0); step();
        drive(0, 1, 0, 0, 100, 1, 0); step();
        chk("midwin_busy", int'(busy), 1);
        chk("midwin_valid", int'(avg_valid), 0);
        drive(0, 1, 0, 0, 100, 1, 0); step();
        drive(0, 1, 0, 0, 100, 1, 0); step();
        chk("midwin_done_valid", int'(avg_valid), 1);
        chk("midwin_done_avg", int'(avg), 100);
`ifdef PWM_ADC_AVG_MINMAX_EN
        chk("midwin_min", int'(min_v), 100);
        chk("midwin_max", int'(max_v), 100);
`endif

        // Random stimulus against the model.
        drive(1, 0, 0, 0, 0, 0, 0);
        model_step();
        step();
        for (int c = 0; c < 3000; c++) begin
            drive(0,
                  ($urandom_range(0, 99) < 95),
                  ($urandom_range(0, 199) < 2),
                  int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)),
                  ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 99) < 40));
            model_step();
            step();
            chk("rnd_valid", int'(avg_valid), m_valid);
            chk("rnd_overrun", int'(overrun), m_ovr);
            chk("rnd_busy", int'(busy), m_busy);
            if (m_valid != 0) begin
                chk("rnd_avg", int'(avg), m_avg);
`ifdef PWM_ADC_AVG_MINMAX_EN
                chk("rnd_min", int'(min_v), m_min);
                chk("rnd_max", int'(max_v), m_max);
`endif
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
